tdm_demux_nto1: RTL and testbench
=================================

Name: tdm_demux_nto1

Overview:
- Time-division demultiplexer: the receive end of a serial channel stream produced by a mux-based serializer.
- Accepts one W-bit word per valid beat, tagged by a frame-start marker on channel 0, and scatters N consecutive words into N parallel channel slots.
- Publishes the complete frame as one registered parallel word with a single-cycle valid pulse.
- Reports frame-sync violations.

Parameters:
- W, 8, width of each channel word in bits
- N, 4, channels per frame; legal range 2..16
- CW, 2, channel counter width; must equal clog2(N)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  W  serial channel word
- din_valid  input  1  din is valid this cycle (one beat)
- frame_start  input  1  qualifies the current beat as channel 0; ignored when din_valid=0
- dout  output  N*W  last completed frame; channel k at dout[k*W +: W]
- frame_valid  output  1  one-cycle pulse: dout has just been updated with a new frame
- sync_err  output  1  one-cycle pulse: frame_start arrived before the current frame completed
- busy  output  1  high while a frame is partially collected (state COLLECT)

Behaviour:
- Reset (asynchronous, active-low):
  - Applies immediately, mid-frame included.
  - dout=0, frame_valid=0, sync_err=0, busy=0.
  - Internal shadow slots cleared, channel counter cnt=0, state=IDLE.
  - The partial frame is discarded.
- States: IDLE (hunting for frame_start), COLLECT (slots 1..N-1 pending). busy = (state==COLLECT).
- Accepted beat: din_valid=1 on a rising clk edge. When din_valid=0, all state holds.
- IDLE:
  - Beat with frame_start=1: shadow[0]<=din, cnt<=1, go to COLLECT.
  - Beat with frame_start=0: discarded, no flag raised.
- COLLECT, beat with frame_start=0:
  - shadow[cnt]<=din.
  - If cnt==N-1: dout<={din, shadow[N-2..0]} (last word merged directly, no extra cycle), frame_valid<=1 for one cycle, cnt<=0, go to IDLE.
  - Otherwise: cnt<=cnt+1.
- COLLECT, beat with frame_start=1 (resync):
  - sync_err<=1 for one cycle.
  - Partial frame dropped; dout unchanged, no frame_valid.
  - shadow[0]<=din, cnt<=1, stay in COLLECT.
- Back-to-back frames: a frame_start beat in the cycle immediately after the completing beat is accepted in IDLE. Zero-gap streaming sustains 1 frame per N cycles.
- Latency:
  - dout and frame_valid change on the same edge that accepts channel N-1's word; visible in the following cycle.
  - frame_valid and sync_err are registered and never combinational from inputs.
- dout holds its value between frames; only frame completion or reset modifies it.
- Stale shadow contents never leak: slots are always fully rewritten before dout publishes.
- Counter never exceeds N-1; no wrap beyond the frame.
- Gaps (din_valid=0) inside a frame are legal and of unbounded length.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> dout=0, frame_valid=0, sync_err=0, busy=0. Assert rst_n=0 mid-cycle -> outputs clear without waiting for a clk edge.
- Basic frame (W=8, N=4): beats 8'hA1(fs=1), 8'hB2, 8'hC3, 8'hD4 on consecutive cycles -> after the 4th edge dout=32'hD4C3B2A1, frame_valid high exactly 1 cycle, busy 1 for 3 cycles then 0.
- Gaps plus pre-sync junk: beats 8'h55, 8'h66 with fs=0 while IDLE, then 8'h01(fs=1), idle 3 cycles, 8'h02, idle 1 cycle, 8'h03, 8'h04 -> junk ignored, dout=32'h04030201, single frame_valid, no sync_err.
- Resync: 8'h11(fs=1), 8'h22, then 8'h33(fs=1), 8'h44, 8'h55, 8'h66 -> sync_err pulse on the third beat, no frame_valid for the aborted frame, then dout=32'h66554433 with frame_valid.
- Back-to-back: two frames with zero gap (0x10..0x13, then 0x20..0x23, fs on the first beat of each) -> frame_valid pulses exactly 4 cycles apart, dout=32'h13121110 then 32'h23222120.
- Reset mid-frame: 8'hAA(fs=1), 8'hBB, then rst_n=0 for 1 cycle, then 8'hCC, 8'hDD with fs=0 -> no frame_valid, dout stays 0, busy=0 (IDLE discards the headless beats).

Source files
------------

// File: rtl/tdm_demux_nto1_if.sv
// Serial-in / frame-out bundle for the TDM demultiplexer; master drives the
// serial beats, slave publishes the reassembled frame and status pulses.
interface tdm_demux_nto1_if #(
   parameter int W = 8,
   parameter int N = 4
);
   logic [W-1:0]   din;
   logic           din_valid;
   logic           frame_start;
   logic [N*W-1:0] dout;
   logic           frame_valid;
   logic           sync_err;
   logic           busy;

   modport master (
      output din, din_valid, frame_start,
      input  dout, frame_valid, sync_err, busy
   );

   modport slave (
      input  din, din_valid, frame_start,
      output dout, frame_valid, sync_err, busy
   );
endinterface

// File: rtl/tdm_demux_nto1.sv
// Scatters N serial words (channel 0 tagged by frame_start) into one registered frame.
// Frame publishes on the edge accepting channel N-1; no backpressure, gaps (din_valid=0) hold all state.
module tdm_demux_nto1 #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int CW = 2
) (
   input logic            clk,
   input logic            rst_n,
   tdm_demux_nto1_if.slave io
);
   typedef enum logic {IDLE, COLLECT} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   shadow_q [N];
   logic [N*W-1:0] dout_q;
   logic [N*W-1:0] frame_next;
   logic           frame_valid_q, sync_err_q;
   logic           wr_en, publish, resync;
   logic [CW-1:0]  wr_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      publish = 1'b0;
      resync  = 1'b0;
      if (io.din_valid) begin
         unique case (state_q)
            IDLE: begin
               // Headless words are dropped silently while hunting for sync.
               if (io.frame_start) begin
                  wr_en   = 1'b1;
                  cnt_d   = CW'(1);
                  state_d = COLLECT;
               end
            end
            COLLECT: begin
               wr_en = 1'b1;
               if (io.frame_start) begin
                  resync = 1'b1;
                  cnt_d  = CW'(1);
               end else begin
                  wr_idx = cnt_q;
                  if (cnt_q == CW'(N-1)) begin
                     publish = 1'b1;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Last channel bypasses its slot so the frame lands on the completing edge.
   always_comb begin
      frame_next = '0;
      for (int k = 0; k < N-1; k++) frame_next[k*W +: W] = shadow_q[k];
      frame_next[(N-1)*W +: W] = io.din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) shadow_q[k] <= '0;
         dout_q        <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         frame_valid_q <= publish;
         sync_err_q    <= resync;
         if (wr_en) shadow_q[wr_idx] <= io.din;
         if (publish) dout_q <= frame_next;
      end
   end

   assign io.dout        = dout_q;
   assign io.frame_valid = frame_valid_q;
   assign io.sync_err    = sync_err_q;
   assign io.busy        = (state_q == COLLECT);
endmodule

// File: tb/tb_tdm_demux_nto1.sv
// Directed and random beats against a queue-based frame reassembly model.
module tb_tdm_demux_nto1;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int CW = 2;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   logic [W-1:0]   m_q[$];
   logic [N*W-1:0] m_dout;
   logic           m_fv;
   logic           m_se;

   tdm_demux_nto1_if #(.W(W), .N(N)) bus ();

   tdm_demux_nto1 #(.W(W), .N(N), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".dout"}, bus.dout, m_dout);
      chk({tag, ".frame_valid"}, (N*W)'(bus.frame_valid), (N*W)'(m_fv));
      chk({tag, ".sync_err"}, (N*W)'(bus.sync_err), (N*W)'(m_se));
      chk({tag, ".busy"}, (N*W)'(bus.busy), (N*W)'(m_q.size() != 0));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = '0;
      m_fv   = 1'b0;
      m_se   = 1'b0;
   endtask

   // One clock: drive, let the edge accept it, update the model, sample 1ns later.
   task automatic beat(input string tag, input logic [W-1:0] d, input logic v, input logic f);
      bus.din         = d;
      bus.din_valid   = v;
      bus.frame_start = f;
      @(posedge clk);
      m_fv = 1'b0;
      m_se = 1'b0;
      if (v) begin
         if (f) begin
            if (m_q.size() != 0) m_se = 1'b1;
            m_q.delete();
            m_q.push_back(d);
         end else if (m_q.size() != 0) begin
            m_q.push_back(d);
            if (m_q.size() == N) begin
               for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_q[k];
               m_fv = 1'b1;
               m_q.delete();
            end
         end
      end
      #1;
      chk_all(tag);
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst_n           = 1'b0;
      bus.din         = '0;
      bus.din_valid   = 1'b0;
      bus.frame_start = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      rst_n = 1'b1;

      // Basic frame
      beat("basic0", 8'hA1, 1'b1, 1'b1);
      beat("basic1", 8'hB2, 1'b1, 1'b0);
      beat("basic2", 8'hC3, 1'b1, 1'b0);
      beat("basic3", 8'hD4, 1'b1, 1'b0);
      chk("basic.const", bus.dout, 32'hD4C3B2A1);
      beat("basic_after", 8'h00, 1'b0, 1'b0);

      // Junk before sync, then gaps inside the frame
      beat("junk0", 8'h55, 1'b1, 1'b0);
      beat("junk1", 8'h66, 1'b1, 1'b0);
      beat("gap0", 8'h01, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) beat("gap_idle", 8'hEE, 1'b0, 1'b1);
      beat("gap1", 8'h02, 1'b1, 1'b0);
      beat("gap_idle", 8'hEE, 1'b0, 1'b0);
      beat("gap2", 8'h03, 1'b1, 1'b0);
      beat("gap3", 8'h04, 1'b1, 1'b0);
      chk("gap.const", bus.dout, 32'h04030201);
      beat("gap_after", 8'h00, 1'b0, 1'b0);

      // Resync mid-frame
      beat("rs0", 8'h11, 1'b1, 1'b1);
      beat("rs1", 8'h22, 1'b1, 1'b0);
      beat("rs2", 8'h33, 1'b1, 1'b1);
      chk("rs.sync_err_const", (N*W)'(bus.sync_err), (N*W)'(1));
      beat("rs3", 8'h44, 1'b1, 1'b0);
      beat("rs4", 8'h55, 1'b1, 1'b0);
      beat("rs5", 8'h66, 1'b1, 1'b0);
      chk("rs.const", bus.dout, 32'h66554433);

      // Back-to-back frames, zero gap
      for (int i = 0; i < N; i++) beat("b2b_a", 8'h10 + 8'(i), 1'b1, i == 0);
      chk("b2b_a.const", bus.dout, 32'h13121110);
      for (int i = 0; i < N; i++) beat("b2b_b", 8'h20 + 8'(i), 1'b1, i == 0);
      chk("b2b_b.const", bus.dout, 32'h23222120);
      beat("b2b_after", 8'h00, 1'b0, 1'b0);

      // Randomized stream: frames, gaps, resyncs, junk
      for (int i = 0; i < 400; i++) begin
         logic v, f;
         v = ($urandom_range(0, 9) < 7);
         f = (m_q.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         beat("rand", 8'($urandom), v, f);
      end

      // Asynchronous reset in the middle of a frame
      beat("mr0", 8'hAA, 1'b1, 1'b1);
      beat("mr1", 8'hBB, 1'b1, 1'b0);
      bus.din_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("async_reset");
      chk("async_reset.dout_zero", bus.dout, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_all("reset_held");
      beat("mr2", 8'hCC, 1'b1, 1'b0);
      beat("mr3", 8'hDD, 1'b1, 1'b0);
      chk("mr.dout_zero", bus.dout, '0);
      beat("mr_after", 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
